dot_product_ctrl: RTL and testbench
===================================

DOT_PRODUCT_CTRL -- requirements
Module: dot_product_ctrl

Interface
REQ-001 SHALL have parameter INPUT_DATA_WIDTH, default 32: operand width.
REQ-002 SHALL have parameter OUTPUT_DATA_WIDTH, default 32: product, accumulator and result width.
REQ-003 SHALL have parameter NUM, default 4: number of multiplier lanes.
REQ-004 SHALL have parameter LEN_WIDTH, default 16: width of the beat-count field.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  job request; sampled only in IDLE.
REQ-009 len  input  LEN_WIDTH  beats in the job; sampled with start.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 in_valid  input  1  operand beat valid.
REQ-012 in_ready  output  1  controller accepts a beat.
REQ-013 in_data  input  [2*NUM-1:0][INPUT_DATA_WIDTH-1:0]  operand pairs; lane i = elements 2i and 2i+1.
REQ-014 mult_in  output  [2*NUM-1:0][INPUT_DATA_WIDTH-1:0]  registered operands to the multiplier array.
REQ-015 mult_out  input  [NUM-1:0][OUTPUT_DATA_WIDTH-1:0]  combinational products from the array.
REQ-016 out_valid  output  1  result valid.
REQ-017 out_ready  input  1  consumer accepts the result.
REQ-018 out_data  output  OUTPUT_DATA_WIDTH  dot-product result.

Function
REQ-019 SHALL implement states IDLE, LOAD, DRAIN and OUT.
REQ-020 IDLE + start, len!=0: go to LOAD, latch len into the beat counter, clear the accumulator and the pipeline valids.
REQ-021 IDLE + start, len==0: go to OUT with out_data=0.
REQ-022 start outside IDLE SHALL be ignored, with no state change and no latch.
REQ-023 in_ready SHALL be 1 only in LOAD; a beat transfers on an edge with in_valid && in_ready.
REQ-024 On each transfer: mult_in <= in_data, stage-1 valid <= 1, beat counter decrements.
REQ-025 On the final beat (counter==1): go to DRAIN; in_ready is 0 from the next cycle.
REQ-026 Stage 2: on the edge after stage-1 valid, capture all NUM mult_out lanes into product registers and set stage-2 valid.
REQ-027 Stage 3: on the edge after stage-2 valid, acc <= acc + sum of the NUM products.
REQ-028 All sums SHALL wrap modulo 2^OUTPUT_DATA_WIDTH, with no saturation and no sign extension beyond OUTPUT_DATA_WIDTH.
REQ-029 Latency: a final beat accepted at edge n gives out_valid=1 and out_data=final acc immediately after edge n+2; DRAIN->OUT occurs at that edge.
REQ-030 Beats with in_valid gaps SHALL be handled: a bubble advances the pipeline with valid=0 and does not change acc.
REQ-031 Throughput: one beat per cycle in LOAD, with no stall while in_valid stays high.
REQ-032 OUT: out_valid stays 1 and out_data is stable until out_valid && out_ready; then go to IDLE with out_valid=0 on that edge.
REQ-033 start in the same cycle as the out handshake SHALL be ignored.
REQ-034 mult_in SHALL hold its last value when no beat transfers.

Reset
REQ-035 rst_n low SHALL immediately set state=IDLE, busy=0, in_ready=0, out_valid=0, out_data=0, mult_in=0, acc=0, counter=0 and all pipeline valids=0.
REQ-036 Reset mid-job SHALL discard partial results; the first post-reset job SHALL be unaffected.
REQ-037 Release of rst_n SHALL be synchronous in effect: no state change until the first rising edge with rst_n high.

Verification
REQ-038 NUM=4, start len=2, beat0 pairs (1,2),(3,4),(5,6),(7,8), beat1 all (1,1), back-to-back, out_ready=1 -> out_data=104 two edges after the beat1 acceptance edge; then IDLE.
REQ-039 start len=0 -> out_valid=1, out_data=0 after the next edge, with in_ready never high.
REQ-040 len=3 with in_valid low one cycle between beats, each beat all (2,3) -> out_data=72; acc unchanged during the gap.
REQ-041 Result ready with out_ready low 5 cycles and start pulsed during OUT -> out_data stable, start ignored, IDLE only after the handshake.
REQ-042 Products overflow: all pairs (0xFFFF,0x10001), len=1, OUTPUT_DATA_WIDTH=32 -> out_data=0xFFFFFFFC (wrapped sum of four 0xFFFFFFFF).
REQ-043 rst_n asserted after 2 of 4 beats -> all outputs 0 immediately; next job len=1, pairs all (1,1) -> out_data=4.

Source files
------------

// File: rtl/dot_product_ctrl.sv
// Dot-product controller: streams operand beats into an external multiplier array,
// registers the products, accumulates them, and hands off one wrapped result per job.
module dot_product_ctrl #(
  parameter int INPUT_DATA_WIDTH  = 32,
  parameter int OUTPUT_DATA_WIDTH = 32,
  parameter int NUM               = 4,
  parameter int LEN_WIDTH         = 16
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [LEN_WIDTH-1:0]                       len,
  output logic                                       busy,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [2*NUM-1:0][INPUT_DATA_WIDTH-1:0]     in_data,
  output logic [2*NUM-1:0][INPUT_DATA_WIDTH-1:0]     mult_in,
  input  logic [NUM-1:0][OUTPUT_DATA_WIDTH-1:0]      mult_out,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [OUTPUT_DATA_WIDTH-1:0]               out_data
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

  state_t                               state, state_nxt;
  logic [LEN_WIDTH-1:0]                 cnt;
  logic                                 s1_valid, s2_valid;
  logic [NUM-1:0][OUTPUT_DATA_WIDTH-1:0] prod;
  logic [OUTPUT_DATA_WIDTH-1:0]         acc, prod_sum, acc_nxt;
  logic                                 xfer;

  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == OUT);
  assign xfer      = in_valid && in_ready;

  // Sums are truncated to OUTPUT_DATA_WIDTH at every step, so they wrap naturally.
  always_comb begin
    prod_sum = '0;
    for (int i = 0; i < NUM; i++) begin
      prod_sum = prod_sum + prod[i];
    end
    acc_nxt = acc + prod_sum;
  end

  // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = (len == '0) ? OUT : LOAD;
      LOAD:  if (xfer && cnt == LEN_WIDTH'(1)) state_nxt = DRAIN;
      // The last product pair is in stage 2 once stage 1 has emptied.
      DRAIN: if (s2_valid && !s1_valid) state_nxt = OUT;
      OUT:   if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the product registers are reset too so a fresh job never sees stale lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_in  <= '0;
      cnt      <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      prod     <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      if (xfer) begin
        mult_in <= in_data;
        cnt     <= cnt - LEN_WIDTH'(1);
      end
      s1_valid <= xfer;
      s2_valid <= s1_valid;
      if (s1_valid) prod <= mult_out;
      if (s2_valid) acc <= acc_nxt;
      if (state == DRAIN && state_nxt == OUT) out_data <= acc_nxt;
      if (state == IDLE && start) begin
        cnt      <= len;
        acc      <= '0;
        s2_valid <= 1'b0;
        if (len == '0) out_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Self-checking bench for dot_product_ctrl: directed jobs with hand-computed results,
// then randomized jobs checked against a transaction-level dot-product model.
module tb_dot_product_ctrl;

  localparam int IW = 32;
  localparam int OW = 32;
  localparam int N  = 4;
  localparam int LW = 16;

  typedef logic [2*N-1:0][IW-1:0] beat_t;

  logic                  clk, rst_n, start, busy;
  logic [LW-1:0]         len;
  logic                  in_valid, in_ready, out_valid, out_ready;
  beat_t                 in_data, mult_in;
  logic [N-1:0][OW-1:0]  mult_out;
  logic [OW-1:0]         out_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [OW-1:0] exp_q[$];
  beat_t job_beats[$];

  dot_product_ctrl #(
    .INPUT_DATA_WIDTH(IW), .OUTPUT_DATA_WIDTH(OW), .NUM(N), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mult_in(mult_in), .mult_out(mult_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [OW-1:0] mul(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [2*IW-1:0] p;
    p = (2*IW)'(a) * (2*IW)'(b);
    return p[OW-1:0];
  endfunction

  // Combinational multiplier array the controller drives.
  always_comb begin
    for (int i = 0; i < N; i++) mult_out[i] = mul(mult_in[2*i], mult_in[2*i+1]);
  end

  // Reference: plain dot product over all beats, wrapped to OW bits.
  function automatic logic [OW-1:0] dot();
    logic [OW-1:0] s;
    s = '0;
    foreach (job_beats[j])
      for (int i = 0; i < N; i++) s = s + mul(job_beats[j][2*i], job_beats[j][2*i+1]);
    return s;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result monitor: every output handshake must deliver the next model result,
  // and out_data must not move while out_valid is held.
  logic          prev_v;
  logic [OW-1:0] prev_d;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && out_valid) check("out_stable", out_data, prev_d);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_result", out_valid, 1'b0);
        else check("result_vs_model", out_data, exp_q.pop_front());
      end
      prev_v = out_valid;
      prev_d = out_data;
    end
  end

  task automatic fill_const(input int n, input logic [IW-1:0] a, input logic [IW-1:0] b);
    beat_t bt;
    job_beats.delete();
    for (int k = 0; k < 2*N; k++) bt[k] = (k % 2 == 0) ? a : b;
    for (int j = 0; j < n; j++) job_beats.push_back(bt);
  endtask

  task automatic fill_rand(input int n);
    beat_t bt;
    job_beats.delete();
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < 2*N; k++) bt[k] = $urandom;
      job_beats.push_back(bt);
    end
  endtask

  // Runs one job from IDLE to the output handshake, starting at a negedge.
  task automatic run_job(input int max_gap, input int gap_pct, input int hold,
                         input bit poke_start, input bit use_pin, input logic [OW-1:0] pin);
    logic [OW-1:0] exp;
    int n;
    n   = job_beats.size();
    exp = dot();
    check("idle_busy", busy, 1'b0);
    check("idle_in_ready", in_ready, 1'b0);
    start = 1'b1;
    len   = LW'(n);
    @(negedge clk);
    start = 1'b0;
    len   = LW'($urandom);
    exp_q.push_back(exp);
    if (n == 0) begin
      check("len0_in_ready", in_ready, 1'b0);
      check("len0_out_valid", out_valid, 1'b1);
      check("len0_out_data", out_data, '0);
    end else begin
      check("load_busy", busy, 1'b1);
      for (int j = 0; j < n; j++) begin
        for (int g = 0; g < max_gap && int'($urandom_range(99)) < gap_pct; g++) begin
          in_valid = 1'b0;
          in_data  = beat_t'({$urandom, $urandom});
          @(negedge clk);
          check("gap_in_ready", in_ready, 1'b1);
          if (j > 0) check("gap_mult_in_hold", mult_in, job_beats[j-1]);
        end
        in_valid = 1'b1;
        in_data  = job_beats[j];
        check("beat_in_ready", in_ready, 1'b1);
        @(negedge clk);
      end
      in_valid = 1'b0;
      check("drain_in_ready", in_ready, 1'b0);
      check("drain_mult_in", mult_in, job_beats[n-1]);
      check("lat_edge0_out_valid", out_valid, 1'b0);
      @(negedge clk);
      check("lat_edge1_out_valid", out_valid, 1'b0);
      @(negedge clk);
      check("lat_edge2_out_valid", out_valid, 1'b1);
      check("lat_edge2_out_data", out_data, exp);
    end
    if (use_pin) check("pinned_result", out_data, pin);
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      if (poke_start) begin
        start = 1'b1;
        len   = LW'(5);
      end
      @(negedge clk);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_busy", busy, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_out_data", out_data, exp);
    end
    out_ready = 1'b1;
    start     = poke_start;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check("post_hs_out_valid", out_valid, 1'b0);
    check("post_hs_busy", busy, 1'b0);
    @(negedge clk);
    check("post_hs_still_idle", busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_mult_in", mult_in, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Two back-to-back beats: 2+12+30+56 + 4*1 = 104.
    job_beats.delete();
    begin
      beat_t b0;
      for (int k = 0; k < 2*N; k++) b0[k] = IW'(k + 1);
      job_beats.push_back(b0);
    end
    job_beats.push_back('{default: IW'(1)});
    run_job(0, 0, 0, 1'b0, 1'b1, 32'd104);

    // Zero-length job returns 0 without accepting beats.
    job_beats.delete();
    run_job(0, 0, 0, 1'b0, 1'b1, 32'd0);

    // One bubble before every beat: 3 beats * 4 lanes * 6 = 72.
    fill_const(3, 32'd2, 32'd3);
    run_job(1, 100, 0, 1'b0, 1'b1, 32'd72);

    // Result held under backpressure with start poked during OUT and at the handshake.
    fill_const(2, 32'd1, 32'd1);
    run_job(0, 0, 5, 1'b1, 1'b1, 32'd8);

    // 0xFFFF * 0x10001 = 0xFFFFFFFF per lane; four of them wrap to 0xFFFFFFFC.
    fill_const(1, 32'h0000_FFFF, 32'h0001_0001);
    run_job(0, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFC);

    // Reset after two of four beats.
    fill_rand(4);
    start = 1'b1;
    len   = LW'(4);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1;
      in_data  = job_beats[j];
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, '0);
    check("midrst_mult_in", mult_in, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_const(1, 32'd1, 32'd1);
    run_job(0, 0, 0, 1'b0, 1'b1, 32'd4);

    // Randomized jobs against the model.
    for (int t = 0; t < 40; t++) begin
      fill_rand(int'($urandom_range(6)));
      run_job(2, 30, int'($urandom_range(3)), 1'($urandom_range(1)), 1'b0, '0);
    end

    @(negedge clk);
    check("results_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
